active_list: RTL

In-order active list (reorder buffer) for the 2-wide out-of-order RISC-V core. It sits alongside rename and receives each renamed instruction's destination mapping. It records completion from execute and retires the oldest instruction each cycle. On each retirement it returns the superseded physical register to the free list over a single-entry `if_freed`/`freed_reg` port. It supplies tail checkpoints for branches and restores its tail on branch recall.

---
 rtl/active_list_if.sv | 55 +++++
 rtl/active_list.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/active_list_if.sv
// ---------------------------------------------------------------------------
// active_list_if
//   Bundle of every non-clock/reset signal of the active list (reorder
//   buffer) of the 2-wide core.
//   master : rename/execute/branch side (drives dispatch, completion,
//            checkpoint request, recall; observes tags, stall, retire).
//   slave  : the active list itself.
//   Groups: dispatch  ext_stall, valid, uses_rd, arch_rd, new_preg, old_preg,
//                     al_tag, int_stall
//           complete  complete_valid, complete_tag
//           branch    make_checkpoint, checkpointed_tail, if_recall,
//                     recalled_tail
//           retire    if_freed, freed_reg, retire_valid, retire_uses_rd,
//                     retire_arch_rd, retire_new_preg
// ---------------------------------------------------------------------------
interface active_list_if #(
   parameter int TAG_W = 5
);
   logic                  ext_stall;
   logic [1:0]            valid;
   logic [1:0]            uses_rd;
   logic [1:0][4:0]       arch_rd;
   logic [1:0][5:0]       new_preg;
   logic [1:0][5:0]       old_preg;
   logic [1:0][TAG_W-1:0] al_tag;
   logic                  int_stall;
   logic [1:0]            complete_valid;
   logic [1:0][TAG_W-1:0] complete_tag;
   logic [1:0]            make_checkpoint;
   logic [TAG_W-1:0]      checkpointed_tail;
   logic                  if_recall;
   logic [TAG_W-1:0]      recalled_tail;
   logic                  if_freed;
   logic [5:0]            freed_reg;
   logic                  retire_valid;
   logic                  retire_uses_rd;
   logic [4:0]            retire_arch_rd;
   logic [5:0]            retire_new_preg;

   modport master (
      output ext_stall, valid, uses_rd, arch_rd, new_preg, old_preg,
             complete_valid, complete_tag, make_checkpoint, if_recall,
             recalled_tail,
      input  al_tag, int_stall, checkpointed_tail, if_freed, freed_reg,
             retire_valid, retire_uses_rd, retire_arch_rd, retire_new_preg
   );

   modport slave (
      input  ext_stall, valid, uses_rd, arch_rd, new_preg, old_preg,
             complete_valid, complete_tag, make_checkpoint, if_recall,
             recalled_tail,
      output al_tag, int_stall, checkpointed_tail, if_freed, freed_reg,
             retire_valid, retire_uses_rd, retire_arch_rd, retire_new_preg
   );
endinterface

// File: rtl/active_list.sv
// ---------------------------------------------------------------------------
// active_list
//   In-order active list for a 2-wide out-of-order core. Accepts up to two
//   renamed instructions per cycle (all-or-nothing), marks completion from
//   two execute ports, retires at most one instruction per cycle from the
//   head, returns the superseded physical register, and supports branch
//   checkpoint/recall of the tail pointer.
//   Ports: clk, reset (synchronous, active-high), al (active_list_if.slave).
// ---------------------------------------------------------------------------
module active_list #(
   parameter int DEPTH = 32,
   parameter int TAG_W = 5
) (
   input logic          clk,
   input logic          reset,
   active_list_if.slave al
);
   typedef logic [TAG_W-1:0] tag_t;
   localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

   // entry state
   logic [DEPTH-1:0]      v_q, v_d, done_q, done_d;
   logic [DEPTH-1:0]      uses_rd_q;
   logic [DEPTH-1:0][4:0] arch_rd_q;
   logic [DEPTH-1:0][5:0] new_preg_q, old_preg_q;

   tag_t           head_q, head_d, tail_q, tail_d;
   logic [TAG_W:0] count_q, count_d;

   // registered retire outputs
   logic       ret_valid_q, ret_uses_q, freed_q;
   logic [4:0] ret_arch_q;
   logic [5:0] ret_new_q, freed_reg_q;

   logic [1:0]            n;
   logic [1:0][TAG_W-1:0] slot_tag;
   logic                  accept, retire;
   logic [TAG_W:0]        n_acc;
   tag_t                  rec_dist, sq_dist;

   assign n           = {1'b0, al.valid[0]} + {1'b0, al.valid[1]};
   // full check deliberately ignores a same-cycle retire
   assign al.int_stall = al.if_recall ||
                         (({1'b0, count_q} + {{TAG_W{1'b0}}, n}) > {1'b0, FULL});
   assign accept      = !al.ext_stall && !al.int_stall;
   assign slot_tag[0] = tail_q;
   assign slot_tag[1] = tail_q + tag_t'(al.valid[0]);
   assign al.al_tag   = slot_tag;
   // head completion in this same cycle is not yet visible in done_q
   assign retire      = v_q[head_q] && done_q[head_q] && !al.if_recall;
   assign n_acc       = accept ? (TAG_W+1)'(n) : '0;

   // checkpoint points one past the branch instruction
   always_comb begin
      al.checkpointed_tail = '0;
      if (al.make_checkpoint[0])      al.checkpointed_tail = tail_q + tag_t'(1);
      else if (al.make_checkpoint[1]) al.checkpointed_tail = tail_q + tag_t'(n);
   end

   always_comb begin
      v_d      = v_q;
      done_d   = done_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      rec_dist = al.recalled_tail - head_q;
      sq_dist  = tail_q - al.recalled_tail;
      if (al.if_recall) begin
         tail_d  = al.recalled_tail;
         // zero distance on a full list means nothing was squashed
         count_d = (rec_dist == '0 && count_q == FULL) ? count_q : {1'b0, rec_dist};
         for (int i = 0; i < DEPTH; i++) begin
            // squash [recalled_tail, old tail) in modular order
            if (tag_t'(i - al.recalled_tail) < sq_dist) begin
               v_d[i]    = 1'b0;
               done_d[i] = 1'b0;
            end
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (al.complete_valid[c] && v_q[al.complete_tag[c]])
               done_d[al.complete_tag[c]] = 1'b1;
         end
         if (retire) begin
            v_d[head_q]    = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + tag_t'(1);
         end
         if (accept) begin
            for (int s = 0; s < 2; s++) begin
               if (al.valid[s]) begin
                  v_d[slot_tag[s]]    = 1'b1;
                  done_d[slot_tag[s]] = 1'b0;
               end
            end
            tail_d = tail_q + tag_t'(n);
         end
         count_d = count_q + n_acc - (TAG_W+1)'(retire);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q         <= '0;
         done_q      <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         ret_valid_q <= 1'b0;
         ret_uses_q  <= 1'b0;
         ret_arch_q  <= '0;
         ret_new_q   <= '0;
         freed_q     <= 1'b0;
         freed_reg_q <= '0;
      end else begin
         v_q         <= v_d;
         done_q      <= done_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         ret_valid_q <= retire;
         ret_uses_q  <= retire ? uses_rd_q[head_q]  : 1'b0;
         ret_arch_q  <= retire ? arch_rd_q[head_q]  : 5'd0;
         ret_new_q   <= retire ? new_preg_q[head_q] : 6'd0;
         freed_q     <= retire ? uses_rd_q[head_q]  : 1'b0;
         freed_reg_q <= retire ? old_preg_q[head_q] : 6'd0;
      end
   end

   // payload is only ever read behind v, so it needs no reset
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int s = 0; s < 2; s++) begin
            if (al.valid[s]) begin
               uses_rd_q[slot_tag[s]]  <= al.uses_rd[s];
               arch_rd_q[slot_tag[s]]  <= al.arch_rd[s];
               new_preg_q[slot_tag[s]] <= al.new_preg[s];
               old_preg_q[slot_tag[s]] <= al.old_preg[s];
            end
         end
      end
   end

   assign al.retire_valid    = ret_valid_q;
   assign al.retire_uses_rd  = ret_uses_q;
   assign al.retire_arch_rd  = ret_arch_q;
   assign al.retire_new_preg = ret_new_q;
   assign al.if_freed        = freed_q;
   assign al.freed_reg       = freed_reg_q;
endmodule
